// File: rtl/wb_cmd_pkg.sv
// Shared types and constants for the wb_cmd_master Wishbone initiator:
// response status encoding, FSM state encoding and data-path width.
package wb_cmd_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    WB_ST_OK      = 2'b00,
    WB_ST_ERR     = 2'b01,
    WB_ST_RTY     = 2'b10,
    WB_ST_TIMEOUT = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  // Watchdog counter width: enough bits for the limit, kept within 8..16.
  function automatic int tmo_cnt_width(input int unsigned limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 8)  return 8;
    if (w > 16) return 16;
    return w;
  endfunction

endpackage

// File: rtl/wb_cmd_master_if.sv
// Bundle of the command stream, response stream and Wishbone bus of wb_cmd_master.
// 'master' is the initiator's view; 'slave' is the view of whatever surrounds it.
interface wb_cmd_master_if #(
  parameter int AW = 4
);
  import wb_cmd_pkg::*;

  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [AW-3:0] cmd_adr_i;
  logic [3:0]    cmd_sel_i;
  logic [DW-1:0] cmd_dat_i;

  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_dat_o;
  logic [1:0]    rsp_status_o;

  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-3:0] wb_adr_o;
  logic [3:0]    wb_sel_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic          wb_rty_i;
  logic          wb_stall_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_dat_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  rsp_ready_i,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_dat_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_status_o,
    output rsp_ready_i,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
  );

endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone pipelined initiator: one command in, one bus cycle, one response out.
// Optional watchdog enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int AW             = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic             clk_i,
  input logic             rst_n_i,
  wb_cmd_master_if.master bus
);

  state_t        r_state, w_next;
  logic          r_cmd_ready, r_cyc, r_stb, r_we, r_rsp_valid;
  logic [AW-3:0] r_adr;
  logic [3:0]    r_sel;
  logic [DW-1:0] r_dat, r_rsp_dat, w_rsp_dat;
  status_t       r_rsp_status, w_status;
  logic          w_busy, w_term, w_tmo, w_cmd_hs, w_rsp_hs;

  // Terminations only count while a cycle is open; stray ones in IDLE/RSP are ignored.
  assign w_busy   = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign w_term   = w_busy & (bus.wb_ack_i | bus.wb_err_i | bus.wb_rty_i);
  assign w_cmd_hs = (r_state == ST_IDLE) & bus.cmd_valid_i & r_cmd_ready;
  assign w_rsp_hs = r_rsp_valid & bus.rsp_ready_i;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam int CW = tmo_cnt_width(TIMEOUT_CYCLES);
  logic [CW-1:0] r_tmo_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)      r_tmo_cnt <= '0;
    else if (w_cmd_hs) r_tmo_cnt <= '0;
    else if (w_busy)   r_tmo_cnt <= r_tmo_cnt + CW'(1);
  end

  // Counter holds the number of completed cycles in REQ/WAIT, so this is the last allowed one.
  assign w_tmo = w_busy & (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_cmd_hs) w_next = ST_REQ;
      ST_REQ: begin
        if (w_term || w_tmo)      w_next = ST_RSP;
        else if (!bus.wb_stall_i) w_next = ST_WAIT;
      end
      ST_WAIT: if (w_term || w_tmo) w_next = ST_RSP;
      ST_RSP:  if (w_rsp_hs) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_status = WB_ST_OK;
    if (bus.wb_err_i)      w_status = WB_ST_ERR;
    else if (bus.wb_rty_i) w_status = WB_ST_RTY;
    else if (bus.wb_ack_i) w_status = WB_ST_OK;
    else if (w_tmo)        w_status = WB_ST_TIMEOUT;
    w_rsp_dat = '0;
    if (!r_we && bus.wb_ack_i && !bus.wb_err_i && !bus.wb_rty_i) w_rsp_dat = bus.wb_dat_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cmd_ready  <= 1'b0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_sel        <= '0;
      r_dat        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_dat    <= '0;
      r_rsp_status <= WB_ST_OK;
    end else begin
      r_cmd_ready <= (w_next == ST_IDLE);
      r_cyc       <= (w_next == ST_REQ) || (w_next == ST_WAIT);
      r_stb       <= (w_next == ST_REQ);
      r_rsp_valid <= (w_next == ST_RSP);
      if (w_cmd_hs) begin
        r_we  <= bus.cmd_we_i;
        r_adr <= bus.cmd_adr_i;
        r_sel <= bus.cmd_sel_i;
        r_dat <= bus.cmd_dat_i;
      end
      if (w_busy && (w_next == ST_RSP)) begin
        r_rsp_status <= w_status;
        r_rsp_dat    <= w_rsp_dat;
      end
    end
  end

  assign bus.cmd_ready_o  = r_cmd_ready;
  assign bus.wb_cyc_o     = r_cyc;
  assign bus.wb_stb_o     = r_stb;
  assign bus.wb_we_o      = r_we;
  assign bus.wb_adr_o     = r_adr;
  assign bus.wb_sel_o     = r_sel;
  assign bus.wb_dat_o     = r_dat;
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_dat_o    = r_rsp_dat;
  assign bus.rsp_status_o = r_rsp_status;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master: read/write, stall, terminations,
// back-pressure, watchdog (both builds of WB_CMD_MASTER_TIMEOUT_EN) and reset mid-cycle.
module tb_wb_cmd_master;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  wb_cmd_master_if #(.AW(4)) bus ();

  wb_cmd_master #(.AW(4), .TIMEOUT_CYCLES(16)) u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; all sampling and driving happens 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic we, input logic [1:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat);
    check("cmd_ready_before_cmd", {31'd0, bus.cmd_ready_o}, 32'd1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_sel_i   = sel;
    bus.cmd_dat_i   = dat;
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic terminate(input logic ack, input logic err, input logic rty,
                           input logic [31:0] dat);
    bus.wb_ack_i = ack;
    bus.wb_err_i = err;
    bus.wb_rty_i = rty;
    bus.wb_dat_i = dat;
    tick();
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_rty_i = 1'b0;
    bus.wb_dat_i = 32'd0;
  endtask

  task automatic take_rsp();
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    check("rsp_valid_after_take", {31'd0, bus.rsp_valid_o}, 32'd0);
    check("cmd_ready_after_take", {31'd0, bus.cmd_ready_o}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int hi;
    rst_n           = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.rsp_ready_i = 1'b0;
    bus.wb_dat_i    = '0;
    bus.wb_ack_i    = 1'b0;
    bus.wb_err_i    = 1'b0;
    bus.wb_rty_i    = 1'b0;
    bus.wb_stall_i  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd0);
    check("rst_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
    check("rst_stb", {31'd0, bus.wb_stb_o}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    check("rst_rsp_dat", bus.rsp_dat_o, 32'd0);
    check("rst_status", {30'd0, bus.rsp_status_o}, 32'd0);
    check("rst_wb_dat", bus.wb_dat_o, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd1);

    // Read, zero-wait slave: handshake at N, ack sampled at N+2, rsp_valid seen after N+2
    do_cmd(1'b0, 2'd2, 4'hF, 32'd0);
    check("rd_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
    check("rd_stb", {31'd0, bus.wb_stb_o}, 32'd1);
    check("rd_we", {31'd0, bus.wb_we_o}, 32'd0);
    check("rd_adr", {30'd0, bus.wb_adr_o}, 32'd2);
    check("rd_cmd_ready_busy", {31'd0, bus.cmd_ready_o}, 32'd0);
    tick();
    check("rd_wait_stb", {31'd0, bus.wb_stb_o}, 32'd0);
    check("rd_wait_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
    check("rd_wait_no_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
    terminate(1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    check("rd_cyc_fall", {31'd0, bus.wb_cyc_o}, 32'd0);
    check("rd_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
    check("rd_rsp_dat", bus.rsp_dat_o, 32'hDEADBEEF);
    check("rd_status", {30'd0, bus.rsp_status_o}, 32'd0);
    take_rsp();

    // Write with 3 stall cycles: stb high for 4 observations, data stable
    bus.wb_stall_i = 1'b1;
    do_cmd(1'b1, 2'd1, 4'hF, 32'h15);
    for (int i = 0; i < 3; i++) begin
      check("wr_stall_stb", {31'd0, bus.wb_stb_o}, 32'd1);
      check("wr_stall_dat", bus.wb_dat_o, 32'h15);
      tick();
    end
    bus.wb_stall_i = 1'b0;
    check("wr_last_stb", {31'd0, bus.wb_stb_o}, 32'd1);
    check("wr_we", {31'd0, bus.wb_we_o}, 32'd1);
    check("wr_sel", {28'd0, bus.wb_sel_o}, 32'hF);
    tick();
    check("wr_wait_stb", {31'd0, bus.wb_stb_o}, 32'd0);
    check("wr_wait_dat", bus.wb_dat_o, 32'h15);
    terminate(1'b1, 1'b0, 1'b0, 32'hAAAAAAAA);
    check("wr_status", {30'd0, bus.rsp_status_o}, 32'd0);
    check("wr_rsp_dat", bus.rsp_dat_o, 32'd0);
    take_rsp();

    // err together with ack: ERR wins, no data
    do_cmd(1'b0, 2'd3, 4'h3, 32'd0);
    tick();
    terminate(1'b1, 1'b1, 1'b0, 32'h12345678);
    check("err_status", {30'd0, bus.rsp_status_o}, 32'd1);
    check("err_rsp_dat", bus.rsp_dat_o, 32'd0);
    take_rsp();

    // rty together with ack: RTY wins
    do_cmd(1'b0, 2'd0, 4'hF, 32'd0);
    tick();
    terminate(1'b1, 1'b0, 1'b1, 32'h87654321);
    check("rty_status", {30'd0, bus.rsp_status_o}, 32'd2);
    check("rty_rsp_dat", bus.rsp_dat_o, 32'd0);
    take_rsp();

    // Termination sampled while still in REQ (stalled): straight to RSP
    bus.wb_stall_i = 1'b1;
    do_cmd(1'b0, 2'd1, 4'hF, 32'd0);
    bus.wb_stall_i = 1'b0;
    terminate(1'b1, 1'b0, 1'b0, 32'hCAFEF00D);
    check("req_ack_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
    check("req_ack_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
    check("req_ack_dat", bus.rsp_dat_o, 32'hCAFEF00D);
    take_rsp();

    // Stray ack while idle is ignored
    terminate(1'b1, 1'b0, 1'b0, 32'h11111111);
    check("idle_ack_ignored", {31'd0, bus.rsp_valid_o}, 32'd0);
    check("idle_ack_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);

    // Back-pressure: response held, no new command accepted
    do_cmd(1'b0, 2'd2, 4'hF, 32'd0);
    tick();
    terminate(1'b1, 1'b0, 1'b0, 32'h0BADCAFE);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b1;
    bus.cmd_adr_i   = 2'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
      check("bp_rsp_dat", bus.rsp_dat_o, 32'h0BADCAFE);
      check("bp_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd0);
      check("bp_no_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
    end
    bus.cmd_valid_i = 1'b0;
    take_rsp();

    // Silent slave: watchdog (TIMEOUT_CYCLES=16) or indefinite wait
    do_cmd(1'b0, 2'd1, 4'hF, 32'd0);
    bus.wb_dat_i = 32'hFFFFFFFF;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.wb_cyc_o) break;
      hi++;
      tick();
    end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    check("tmo_cyc_cycles", hi, 32'd16);
    check("tmo_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
    check("tmo_status", {30'd0, bus.rsp_status_o}, 32'd3);
    check("tmo_rsp_dat", bus.rsp_dat_o, 32'd0);
    bus.wb_dat_i = 32'd0;
`else
    check("no_tmo_cyc_held", hi, 32'd40);
    check("no_tmo_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    terminate(1'b1, 1'b0, 1'b0, 32'h600DD00D);
    check("no_tmo_status", {30'd0, bus.rsp_status_o}, 32'd0);
    check("no_tmo_rsp_dat", bus.rsp_dat_o, 32'h600DD00D);
`endif
    take_rsp();

    // Reset mid-WAIT, then a fresh read completes normally
    do_cmd(1'b1, 2'd2, 4'hA, 32'h77);
    tick();
    check("pre_rst_wait_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
    check("midrst_stb", {31'd0, bus.wb_stb_o}, 32'd0);
    check("midrst_adr", {30'd0, bus.wb_adr_o}, 32'd0);
    check("midrst_dat", bus.wb_dat_o, 32'd0);
    check("midrst_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd0);
    check("midrst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    tick();
    do_cmd(1'b0, 2'd2, 4'hF, 32'd0);
    tick();
    terminate(1'b1, 1'b0, 1'b0, 32'h5A5A5A5A);
    check("post_rst_rd_dat", bus.rsp_dat_o, 32'h5A5A5A5A);
    check("post_rst_rd_status", {30'd0, bus.rsp_status_o}, 32'd0);
    take_rsp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
